// File: rtl/inst_stream_ctrl.sv
// Instruction feed controller between a valid/ready host stream and the cpu
// start/instruction interface. Buffers the program in a small FIFO, starts the
// cpu after a prefill, issues one instruction per non-stalled cycle (NOPs on
// underflow) and flushes with NOPs after the last instruction before done.
module inst_stream_ctrl #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned PREFILL      = 2,
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter logic [31:0] NOP_INST     = 32'h00000013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_host_valid,
   input  logic [31:0] i_host_inst,
   input  logic        i_host_last,
   output logic        o_host_ready,
   input  logic        i_cpu_stall,
   output logic        o_cpu_start,
   output logic [31:0] o_cpu_inst,
   output logic        o_done,
   output logic [15:0] o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1) + 1;

   localparam logic [LW-1:0] FULL_LEVEL    = LW'(DEPTH);
   localparam logic [LW-1:0] PREFILL_LEVEL = LW'(PREFILL);
   localparam logic [LW-1:0] LEVEL_ONE     = LW'(1);
   localparam logic [PW-1:0] PTR_ONE       = PW'(1);
   localparam logic [FW-1:0] FLUSH_LAST    = FW'(FLUSH_CYCLES);
   localparam logic [FW-1:0] FLUSH_ONE     = FW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [32:0]   mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q;
   logic [PW-1:0] rdPtr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          lastSeen_q;
   logic          lastSeen_d;
   logic          hostReady_q;
   logic          hostReady_d;
   logic          cpuStart_q;
   logic [31:0]   cpuInst_q;
   logic          done_q;
   logic [15:0]   count_q;
   logic [FW-1:0] flushCnt_q;

   logic          push;
   logic          pop;
   logic          goRun;
   logic          runIssue;
   logic          flushStep;
   logic          enterDone;
   logic [32:0]   head;

   assign o_host_ready = hostReady_q;
   assign o_cpu_start  = cpuStart_q;
   assign o_cpu_inst   = cpuInst_q;
   assign o_done       = done_q;
   assign o_count      = count_q;

   // Per-cycle handshake, issue decision and next FIFO level / ready.
   always_comb begin
      push      = i_host_valid && hostReady_q;
      goRun     = (state_q == S_IDLE) && ((level_q >= PREFILL_LEVEL) || lastSeen_q);
      runIssue  = (state_q == S_RUN) && !i_cpu_stall;
      pop       = (goRun || runIssue) && (level_q != '0);
      flushStep = (state_q == S_FLUSH) && !i_cpu_stall;
      enterDone = flushStep && (flushCnt_q == FLUSH_LAST);
      head      = mem_q[rdPtr_q];
      level_d   = level_q;
      if (push && !pop) begin
         level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LEVEL_ONE;
      end
      lastSeen_d  = lastSeen_q || (push && i_host_last);
      hostReady_d = (level_d != FULL_LEVEL) && !lastSeen_d && !enterDone &&
                    (state_q != S_DONE);
   end

   // FIFO storage; validity is defined by the pointers so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {i_host_last, i_host_inst};
      end
   end

   // FIFO pointers, level, last-seen flag and registered host ready.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         lastSeen_q  <= 1'b0;
         hostReady_q <= 1'b0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_ONE;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
         level_q     <= level_d;
         lastSeen_q  <= lastSeen_d;
         hostReady_q <= hostReady_d;
      end
   end

   // Issue state machine with registered cpu-side outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cpuStart_q <= 1'b0;
         cpuInst_q  <= '0;
         done_q     <= 1'b0;
         count_q    <= '0;
         flushCnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_RUN: begin
               if (goRun || runIssue) begin
                  cpuStart_q <= 1'b1;
                  if (pop) begin
                     cpuInst_q <= head[31:0];
                     if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'd1;
                     end
                     if (head[32]) begin
                        state_q    <= S_FLUSH;
                        flushCnt_q <= '0;
                     end else begin
                        state_q <= S_RUN;
                     end
                  end else begin
                     cpuInst_q <= NOP_INST;
                     state_q   <= S_RUN;
                  end
               end
            end
            S_FLUSH: begin
               if (enterDone) begin
                  state_q    <= S_DONE;
                  cpuStart_q <= 1'b0;
                  cpuInst_q  <= '0;
                  done_q     <= 1'b1;
               end else if (flushStep) begin
                  cpuInst_q  <= NOP_INST;
                  flushCnt_q <= flushCnt_q + FLUSH_ONE;
               end
            end
            S_DONE: begin
               cpuStart_q <= 1'b0;
               cpuInst_q  <= '0;
               done_q     <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_stream_ctrl.sv
// Testbench for inst_stream_ctrl: directed scenarios plus randomized programs,
// every output compared each cycle against a queue-based behavioural model.
module tb_inst_stream_ctrl;

   localparam int          DEPTH        = 8;
   localparam int          PREFILL      = 2;
   localparam int          FLUSH_CYCLES = 4;
   localparam logic [31:0] NOP_INST     = 32'h00000013;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_FLUSH = 2;
   localparam int P_DONE  = 3;

   logic        clk = 1'b0;
   logic        rstN;
   logic        hostValid;
   logic [31:0] hostInst;
   logic        hostLast;
   logic        hostReady;
   logic        cpuStall;
   logic        cpuStart;
   logic [31:0] cpuInst;
   logic        done;
   logic [15:0] count;

   int testsRun = 0;
   int testsFailed = 0;

   // Behavioural model: program queue plus phase of the feed.
   logic [32:0] mFifo[$];
   int          mPhase;
   int          mNopsLeft;
   int          mCount;
   bit          mLastSeen;
   bit          mReady;
   bit          mStart;
   bit          mDone;
   logic [31:0] mInst;

   // Host side program still to be offered, and stimulus knobs.
   logic [32:0] hostQ[$];
   int          hostGap;
   int          gapLeft;
   int          stallMode;
   int          len;

   // Free-running clock.
   always #5 clk = ~clk;

   inst_stream_ctrl #(
      .DEPTH(DEPTH),
      .PREFILL(PREFILL),
      .FLUSH_CYCLES(FLUSH_CYCLES),
      .NOP_INST(NOP_INST)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_host_valid(hostValid),
      .i_host_inst(hostInst),
      .i_host_last(hostLast),
      .o_host_ready(hostReady),
      .i_cpu_stall(cpuStall),
      .o_cpu_start(cpuStart),
      .o_cpu_inst(cpuInst),
      .o_done(done),
      .o_count(count)
   );

   function automatic void modelReset();
      mFifo.delete();
      mPhase    = P_IDLE;
      mNopsLeft = 0;
      mCount    = 0;
      mLastSeen = 0;
      mReady    = 0;
      mStart    = 0;
      mDone     = 0;
      mInst     = 32'h0;
   endfunction

   // One clock of the model: issue from the queue as it stood, then accept the host word.
   function automatic void modelStep(bit v, logic [31:0] w, bit l, bit s);
      bit          pushNow;
      bit          issueNow;
      logic [32:0] e;
      pushNow  = v && mReady;
      issueNow = (mPhase == P_IDLE && (mFifo.size() >= PREFILL || mLastSeen)) ||
                 (mPhase == P_RUN && !s);
      if (issueNow) begin
         mStart = 1;
         if (mFifo.size() > 0) begin
            e     = mFifo.pop_front();
            mInst = e[31:0];
            if (mCount < 65535) mCount++;
            if (e[32]) begin
               mPhase    = P_FLUSH;
               mNopsLeft = FLUSH_CYCLES;
            end else begin
               mPhase = P_RUN;
            end
         end else begin
            mInst  = NOP_INST;
            mPhase = P_RUN;
         end
      end else if (mPhase == P_FLUSH && !s) begin
         if (mNopsLeft == 0) begin
            mPhase = P_DONE;
            mInst  = 32'h0;
            mStart = 0;
            mDone  = 1;
         end else begin
            mInst = NOP_INST;
            mNopsLeft--;
         end
      end
      if (pushNow) begin
         mFifo.push_back({l, w});
         if (l) mLastSeen = 1;
      end
      mReady = (mFifo.size() < DEPTH) && !mLastSeen && (mPhase != P_DONE);
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkVal("hostReady", 32'(hostReady), 32'(mReady));
      checkVal("cpuStart", 32'(cpuStart), 32'(mStart));
      checkVal("cpuInst", cpuInst, mInst);
      checkVal("done", 32'(done), 32'(mDone));
      checkVal("count", 32'(count), 32'(mCount));
   endtask

   // Called at a falling edge: drive inputs, advance model, clock once, compare.
   task automatic applyStimulus(input bit v, input logic [31:0] w, input bit l,
                                input bit s, output bit acc);
      hostValid = v;
      hostInst  = w;
      hostLast  = l;
      cpuStall  = s;
      acc       = v && mReady;
      modelStep(v, w, l, s);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic cycle();
      bit          v;
      bit          l;
      bit          s;
      bit          acc;
      logic [31:0] w;
      logic [32:0] e;
      v = 0;
      w = $urandom;
      l = 1'($urandom_range(0, 1));
      if (hostQ.size() > 0 && gapLeft == 0) begin
         v = 1;
         e = hostQ[0];
         l = e[32];
         w = e[31:0];
      end
      if (stallMode == 1) s = ($urandom_range(0, 3) == 0);
      else s = (stallMode == 2);
      applyStimulus(v, w, l, s, acc);
      if (acc) begin
         e = hostQ.pop_front();
         gapLeft = hostGap;
      end else if (!v && gapLeft > 0) begin
         gapLeft--;
      end
   endtask

   task automatic loadWord(input logic [31:0] w, input bit l);
      hostQ.push_back({l, w});
   endtask

   task automatic runUntilDone(input int budget, input int expLen, input string tag);
      for (int i = 0; i < budget && !mDone; i++) cycle();
      cycle();
      checkVal({tag, "_done"}, 32'(done), 32'd1);
      checkVal({tag, "_count"}, 32'(count), 32'(expLen));
      checkVal({tag, "_inst"}, cpuInst, 32'h0);
   endtask

   // Asynchronous reset dropped mid-cycle, checked before the next clock edge.
   task automatic doReset();
      #2 rstN = 1'b0;
      hostValid = 1'b0;
      hostLast  = 1'b0;
      cpuStall  = 1'b0;
      modelReset();
      hostQ.delete();
      gapLeft = 0;
      #1 checkOutput();
      @(posedge clk);
      @(negedge clk);
      checkOutput();
      rstN = 1'b1;
   endtask

   // Directed and randomized scenarios in sequence.
   initial begin
      rstN      = 1'b1;
      hostValid = 1'b0;
      hostInst  = 32'h0;
      hostLast  = 1'b0;
      cpuStall  = 1'b0;
      stallMode = 0;
      hostGap   = 0;
      gapLeft   = 0;
      modelReset();
      #1;
      doReset();

      // Basic three-word program.
      loadWord(32'h00500093, 1'b0);
      loadWord(32'h00A00113, 1'b0);
      loadWord(32'h002081B3, 1'b1);
      runUntilDone(60, 3, "basic");

      // Two stalled cycles while the second word is presented.
      doReset();
      loadWord(32'h00500093, 1'b0);
      loadWord(32'h00A00113, 1'b0);
      loadWord(32'h002081B3, 1'b1);
      for (int i = 0; i < 30 && mInst != 32'h00A00113; i++) cycle();
      stallMode = 2;
      cycle();
      cycle();
      checkVal("stall_hold", cpuInst, 32'h00A00113);
      checkVal("stall_count", 32'(count), 32'd2);
      stallMode = 0;
      runUntilDone(60, 3, "stall");

      // FIFO fills while the cpu is stalled, then drains in order.
      doReset();
      stallMode = 2;
      for (int i = 1; i <= 10; i++) loadWord(32'(i), (i == 10));
      repeat (20) cycle();
      checkVal("full_ready", 32'(hostReady), 32'd0);
      checkVal("full_count", 32'(count), 32'd1);
      checkVal("full_inst", cpuInst, 32'h1);
      stallMode = 0;
      runUntilDone(80, 10, "full");

      // Host gaps cause NOP insertion.
      doReset();
      hostGap = 3;
      for (int i = 0; i < 5; i++) loadWord($urandom, (i == 4));
      runUntilDone(100, 5, "underflow");
      hostGap = 0;

      // Single-word program starts via the last flag.
      doReset();
      loadWord(32'h00100073, 1'b1);
      runUntilDone(40, 1, "short");

      // Reset after two issued words, then a fresh program.
      doReset();
      for (int i = 0; i < 6; i++) loadWord(32'h100 + 32'(i), (i == 5));
      for (int i = 0; i < 40 && mCount < 2; i++) cycle();
      checkVal("preReset_count", 32'(count), 32'd2);
      doReset();
      loadWord(32'h00300213, 1'b0);
      loadWord(32'h00400293, 1'b0);
      loadWord(32'h00500313, 1'b1);
      runUntilDone(60, 3, "afterReset");

      // Randomized programs with random stalls and host gaps.
      for (int t = 0; t < 4; t++) begin
         doReset();
         hostGap   = $urandom_range(0, 2);
         stallMode = 1;
         len       = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) loadWord($urandom, (i == len - 1));
         runUntilDone(400, len, "random");
         stallMode = 0;
         hostGap   = 0;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
